// File: rtl/track_supervisor.sv
// Range-sensor track supervisor: per-channel hit qualification, SCAN/LOCK/WAIT_CLEAR/MANUAL FSM.
// Define TRACK_SUPERVISOR_EVT_EN to enable the state-change event outputs (evt_vld/evt_code).
module track_supervisor #(
    parameter int NUM_CH       = 4,
    parameter int DIST_W       = 16,
    parameter int LOCK_CYCLES  = 100_000_000,
    parameter int CLEAR_CYCLES = 5_000_000,
    parameter int HIT_COUNT    = 3
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           manual_tgl,
    input  logic [DIST_W-1:0]                              trig_cm,
    input  logic [NUM_CH-1:0]                              sample_vld,
    input  logic [NUM_CH*DIST_W-1:0]                       sample_cm,
    output logic [1:0]                                     state,
    output logic                                           freeze,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] lock_ch,
    output logic [DIST_W-1:0]                              lock_cm,
    output logic [2:0]                                     rgb,
    output logic                                           evt_vld,
    output logic [1:0]                                     evt_code
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HC_W    = $clog2(HIT_COUNT + 1);
    localparam int TIMER_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam int CLR_W   = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_LOCK   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_MANUAL = 2'd3
    } st_t;

    st_t                st_q, nxt;
    logic [HC_W-1:0]    hit_cnt [NUM_CH];
    logic [DIST_W-1:0]  last_cm [NUM_CH];
    logic [NUM_CH-1:0]  active;
    logic [TIMER_W-1:0] lock_timer;
    logic [CLR_W-1:0]   clr_cnt;
    logic               any_act;
    logic [CH_W-1:0]    sel_ch;
    logic [DIST_W-1:0]  sel_cm;
    logic               go_manual;

    function automatic logic [HC_W-1:0] sat_inc(input logic [HC_W-1:0] v);
        return (v >= HC_W'(HIT_COUNT)) ? v : v + 1'b1;
    endfunction

    function automatic logic [2:0] rgb_of(input st_t s);
        case (s)
            ST_SCAN:  return 3'b010;
            ST_LOCK:  return 3'b100;
            ST_WAIT:  return 3'b001;
            default:  return 3'b111;
        endcase
    endfunction

    assign go_manual = manual_tgl && (st_q != ST_MANUAL);
    assign state     = st_q;

    // Counters are held clear while in MANUAL, including the edges that enter and leave it
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (reset || go_manual || st_q == ST_MANUAL) begin
                hit_cnt[i] <= '0;
                if (reset) last_cm[i] <= '0;
            end else if (sample_vld[i]) begin
                if (sample_cm[i*DIST_W +: DIST_W] != '0 &&
                    sample_cm[i*DIST_W +: DIST_W] <= trig_cm) begin
                    hit_cnt[i] <= sat_inc(hit_cnt[i]);
                    last_cm[i] <= sample_cm[i*DIST_W +: DIST_W];
                end else begin
                    hit_cnt[i] <= '0;
                end
            end
        end
    end

    // Nearest active channel wins; strict less-than keeps ties on the lowest index
    always_comb begin
        active  = '0;
        any_act = 1'b0;
        sel_ch  = '0;
        sel_cm  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active[i] = (hit_cnt[i] == HC_W'(HIT_COUNT));
            if (active[i] && (!any_act || last_cm[i] < sel_cm)) begin
                any_act = 1'b1;
                sel_ch  = CH_W'(i);
                sel_cm  = last_cm[i];
            end
        end
    end

    always_comb begin
        nxt = st_q;
        case (st_q)
            ST_SCAN:   if (any_act) nxt = ST_LOCK;
            ST_LOCK:   if (lock_timer == '0) nxt = ST_WAIT;
            ST_WAIT:   if (!any_act && clr_cnt == CLR_W'(CLEAR_CYCLES - 1)) nxt = ST_SCAN;
            ST_MANUAL: if (manual_tgl) nxt = ST_SCAN;
            default:   nxt = ST_SCAN;
        endcase
        if (go_manual) nxt = ST_MANUAL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q       <= ST_SCAN;
            freeze     <= 1'b0;
            rgb        <= 3'b010;
            lock_ch    <= '0;
            lock_cm    <= '0;
            lock_timer <= '0;
            clr_cnt    <= '0;
        end else begin
            st_q   <= nxt;
            freeze <= (nxt == ST_LOCK);
            rgb    <= rgb_of(nxt);

            if (st_q == ST_SCAN && nxt == ST_LOCK) begin
                lock_ch    <= sel_ch;
                lock_cm    <= sel_cm;
                lock_timer <= TIMER_W'(LOCK_CYCLES - 1);
            end else if (st_q == ST_LOCK && lock_timer != '0) begin
                lock_timer <= lock_timer - 1'b1;
            end

            if (st_q != ST_WAIT || any_act) begin
                clr_cnt <= '0;
            end else if (nxt == ST_WAIT) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end

`ifdef TRACK_SUPERVISOR_EVT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            evt_vld  <= 1'b0;
            evt_code <= 2'd0;
        end else begin
            evt_vld <= (nxt != st_q);
            if (nxt != st_q) evt_code <= nxt;
        end
    end
`else
    assign evt_vld  = 1'b0;
    assign evt_code = 2'd0;
`endif

endmodule

// File: doc/track_supervisor.md
TRACK_SUPERVISOR -- requirements
Module: track_supervisor

Interface
REQ-001 SHALL provide parameter NUM_CH, default 4, number of range-sensor channels (1..8).
REQ-002 SHALL provide parameter DIST_W, default 16, width of each distance in cm.
REQ-003 SHALL provide parameter LOCK_CYCLES, default 100_000_000, LOCK dwell in clocks (2 s at 50 MHz).
REQ-004 SHALL provide parameter CLEAR_CYCLES, default 5_000_000, consecutive no-target clocks required to leave WAIT_CLEAR.
REQ-005 SHALL provide parameter HIT_COUNT, default 3, consecutive in-range samples required to declare a channel active.
REQ-006 SHALL provide clk  input  1  system clock; one clock domain only.
REQ-007 SHALL provide reset  input  1  synchronous, active-high reset.
REQ-008 SHALL provide manual_tgl  input  1  single-cycle manual-mode toggle pulse.
REQ-009 SHALL provide trig_cm  input  DIST_W  trigger distance threshold.
REQ-010 SHALL provide sample_vld  input  NUM_CH  per-channel new-sample strobe.
REQ-011 SHALL provide sample_cm  input  NUM_CH*DIST_W  per-channel distance; channel i occupies bits [i*DIST_W +: DIST_W].
REQ-012 SHALL provide state  output  2  0=SCAN, 1=LOCK, 2=WAIT_CLEAR, 3=MANUAL.
REQ-013 SHALL provide freeze  output  1  servo hold request.
REQ-014 SHALL provide lock_ch  output  max(1,$clog2(NUM_CH))  index of locked channel.
REQ-015 SHALL provide lock_cm  output  DIST_W  distance captured at lock.
REQ-016 SHALL provide rgb  output  3  {red,green,blue} status LEDs.
REQ-017 SHALL provide evt_vld  output  1  and evt_code  output  2  state-change event.

Function
REQ-018 On sample_vld[i]: if sample_cm[i] != 0 and <= trig_cm, hit counter i increments, saturating at HIT_COUNT, and last_cm[i] <= sample_cm[i]; otherwise hit counter i clears to 0.
REQ-019 Channel i is active when its hit counter equals HIT_COUNT; counters without sample_vld hold their value.
REQ-020 SCAN -> LOCK on the clock after any channel is active; lock_ch <= active channel with smallest last_cm, ties to lowest index; lock_cm <= that last_cm.
REQ-021 LOCK SHALL last exactly LOCK_CYCLES clocks (timer loaded LOCK_CYCLES-1 on entry, exit when it reads 0), then -> WAIT_CLEAR.
REQ-022 WAIT_CLEAR counts clocks with no channel active, restarting from 0 on any active cycle; -> SCAN when count reaches CLEAR_CYCLES.
REQ-023 manual_tgl in SCAN, LOCK or WAIT_CLEAR -> MANUAL next clock, overriding all other transitions; manual_tgl in MANUAL -> SCAN.
REQ-024 Entry into MANUAL SHALL clear all hit counters; counters stay cleared while in MANUAL.
REQ-025 freeze = 1 only in LOCK; registered, aligned with state.
REQ-026 rgb: SCAN 010, LOCK 100, WAIT_CLEAR 001, MANUAL 111.
REQ-027 lock_ch/lock_cm hold until the next SCAN -> LOCK capture.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 reset SHALL force state=SCAN, freeze=0, lock_ch=0, lock_cm=0, rgb=010, evt_vld=0, evt_code=0, all hit counters, last_cm, LOCK timer and clear counter to 0.
REQ-030 reset asserted mid-LOCK or mid-MANUAL SHALL take effect on the next clock edge with no event emitted.

Configuration
REQ-031 With TRACK_SUPERVISOR_EVT_EN defined, evt_vld pulses one clock on each state change, aligned with the new state, with evt_code = new state.
REQ-032 Without TRACK_SUPERVISOR_EVT_EN, evt_vld and evt_code SHALL be constant 0 and event logic SHALL be absent.

Verification (NUM_CH=2, DIST_W=16, LOCK_CYCLES=8, CLEAR_CYCLES=4, HIT_COUNT=2)
REQ-033 trig_cm=50; ch0 samples 40,40 -> state=LOCK and freeze=1 one clock after second sample; LOCK lasts exactly 8 clocks; lock_ch=0, lock_cm=40.
REQ-034 Both channels reach active in the same cycle, ch0=30, ch1=20 -> lock_ch=1, lock_cm=20; repeat with equal 20/20 -> lock_ch=0.
REQ-035 ch0 samples 40,60,40 -> no LOCK (miss clears counter); sample_cm=0 with trig_cm=50 -> no hit.
REQ-036 In WAIT_CLEAR, target active for 3 more clocks then removed -> SCAN exactly 4 clocks after last active cycle.
REQ-037 manual_tgl during LOCK -> MANUAL next clock, rgb=111, freeze=0; second pulse -> SCAN, counters 0; with EVT_EN, evt_code sequence 3 then 0.
REQ-038 reset pulse mid-LOCK -> next clock state=SCAN, freeze=0, lock_cm=0, evt_vld=0.
